// File: rtl/instr_assembler.sv
// Assembles 6502 instructions (opcode + 0..2 operand bytes) from an in-order byte
// stream, tags each with its fetch PC and holds it in a one-entry output register.
module instr_assembler #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] dout_pc,
    output logic [7:0]  dout_opcode,
    output logic [15:0] dout_operand,
    output logic [1:0]  dout_len,
    output logic        dout_valid,
    input  logic        dout_ready
);

    typedef enum logic [1:0] {
        S_OPC,
        S_LO,
        S_HI,
        S_FULL
    } state_t;

    state_t      state_q,   state_d;
    logic [15:0] next_pc_q, next_pc_d;
    logic [15:0] pc_q,      pc_d;
    logic [7:0]  opcode_q,  opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [1:0]  len_q,     len_d;
    logic        accept;

    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [3:0] h;
        logic [3:0] n;
        h = op[7:4];
        n = op[3:0];
        case (n)
            4'h0:    op_len = (h == 4'h2) ? 2'd3 : ((h == 4'h4 || h == 4'h6) ? 2'd1 : 2'd2);
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: op_len = 2'd2;
            4'h2:    op_len = (h[3] && !h[0]) ? 2'd2 : 2'd1;
            4'h8, 4'hA: op_len = 2'd1;
            4'h9, 4'hB: op_len = h[0] ? 2'd3 : 2'd2;
            default: op_len = 2'd3;
        endcase
    endfunction

    // Ready is independent of din_valid; in FULL a new opcode may load as the held one drains.
    assign din_ready = !redirect_valid && ((state_q != S_FULL) || dout_ready);
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d   = state_q;
        next_pc_d = next_pc_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        len_d     = len_q;

        if (redirect_valid) begin
            state_d   = S_OPC;
            next_pc_d = redirect_pc;
        end else begin
            if (accept) begin
                next_pc_d = next_pc_q + 16'd1;
            end
            case (state_q)
                S_OPC, S_FULL: begin
                    if (accept) begin
                        opcode_d  = din;
                        pc_d      = next_pc_q;
                        operand_d = '0;
                        len_d     = op_len(din);
                        state_d   = (op_len(din) == 2'd1) ? S_FULL : S_LO;
                    end else if (state_q == S_FULL && dout_ready) begin
                        state_d = S_OPC;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        operand_d[7:0] = din;
                        state_d        = (len_q == 2'd2) ? S_FULL : S_HI;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        operand_d[15:8] = din;
                        state_d         = S_FULL;
                    end
                end
                default: state_d = S_OPC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OPC;
            next_pc_q <= RESET_PC;
            pc_q      <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            next_pc_q <= next_pc_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            len_q     <= len_d;
        end
    end

    assign dout_valid   = (state_q == S_FULL);
    assign dout_pc      = pc_q;
    assign dout_opcode  = opcode_q;
    assign dout_operand = operand_q;
    assign dout_len     = len_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Scoreboard bench for instr_assembler: directed byte streams push expected
// instructions; a negedge monitor pops and compares on every output handshake.
module tb_instr_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] dout_pc;
    logic [7:0]  dout_opcode;
    logic [15:0] dout_operand;
    logic [1:0]  dout_len;
    logic        dout_valid;
    logic        dout_ready;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [1:0]  len;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned hs_cyc[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned last_wait;

    instr_assembler #(.RESET_PC(16'h0200)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dout_pc(dout_pc), .dout_opcode(dout_opcode), .dout_operand(dout_operand),
        .dout_len(dout_len), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [15:0] pc, input logic [7:0] op,
                        input logic [15:0] opnd, input logic [1:0] len);
        exp_t e;
        e.pc = pc; e.op = op; e.opnd = opnd; e.len = len;
        exp_q.push_back(e);
    endtask

    // Monitor: a handshake completes at the next posedge when valid & ready at negedge.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_output_pc", {16'h0, dout_pc}, 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dout_pc",      {16'h0, dout_pc},      {16'h0, e.pc});
                chk("dout_opcode",  {24'h0, dout_opcode},  {24'h0, e.op});
                chk("dout_operand", {16'h0, dout_operand}, {16'h0, e.opnd});
                chk("dout_len",     {30'h0, dout_len},     {30'h0, e.len});
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        logic acc;
        n = 0;
        acc = 1'b0;
        din = b;
        din_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            n++;
        end
        din_valid = 1'b0;
        last_wait = n;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; dout_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_dout_valid",   {31'h0, dout_valid}, 32'd0);
        chk("rst_din_ready",    {31'h0, din_ready},  32'd1);
        chk("rst_dout_pc",      {16'h0, dout_pc},    32'd0);
        chk("rst_dout_opcode",  {24'h0, dout_opcode}, 32'd0);
        chk("rst_dout_operand", {16'h0, dout_operand}, 32'd0);
        chk("rst_dout_len",     {30'h0, dout_len},   32'd0);
        @(posedge clk); #1;

        // LDA #imm
        push(16'h0200, 8'hA9, 16'h0005, 2'd2);
        send_byte(8'hA9);
        send_byte(8'h05);
        idle(3);

        // JMP abs then NOP, back-to-back with no stall
        do_reset();
        hs_cyc.delete();
        push(16'h0200, 8'h4C, 16'h1234, 2'd3);
        push(16'h0203, 8'hEA, 16'h0000, 2'd1);
        send_byte(8'h4C); chk("jmp_b0_nostall", last_wait, 32'd1);
        send_byte(8'h34); chk("jmp_b1_nostall", last_wait, 32'd1);
        send_byte(8'h12); chk("jmp_b2_nostall", last_wait, 32'd1);
        send_byte(8'hEA); chk("nop_nostall",    last_wait, 32'd1);
        idle(3);
        chk("jmp_nop_hs_count", hs_cyc.size(), 32'd2);
        if (hs_cyc.size() == 2) chk("jmp_nop_consecutive", hs_cyc[1] - hs_cyc[0], 32'd1);

        // INX held under backpressure
        do_reset();
        hs_cyc.delete();
        dout_ready = 1'b0;
        push(16'h0200, 8'hE8, 16'h0000, 2'd1);
        push(16'h0201, 8'hE8, 16'h0000, 2'd1);
        send_byte(8'hE8);
        din = 8'hE8; din_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("full_din_ready",  {31'h0, din_ready},  32'd0);
            chk("full_dout_valid", {31'h0, dout_valid}, 32'd1);
            @(posedge clk); #1;
        end
        dout_ready = 1'b1;
        send_byte(8'hE8);
        chk("inx2_accept_on_drain", last_wait, 32'd1);
        idle(3);
        chk("inx_hs_count", hs_cyc.size(), 32'd2);
        if (hs_cyc.size() == 2) chk("inx_consecutive", hs_cyc[1] - hs_cyc[0], 32'd1);

        // Partial JSR flushed by redirect
        send_byte(8'h20);
        send_byte(8'h00);
        redirect_valid = 1'b1; redirect_pc = 16'h8000;
        din = 8'h60; din_valid = 1'b1;
        @(negedge clk);
        chk("redirect_din_ready", {31'h0, din_ready}, 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        din_valid = 1'b0;
        push(16'h8000, 8'h60, 16'h0000, 2'd1);
        send_byte(8'h60);
        idle(3);

        // PC wrap through FFFF
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        idle(1);
        redirect_valid = 1'b0;
        push(16'hFFFE, 8'hAD, 16'h2010, 2'd3);
        push(16'h0001, 8'hEA, 16'h0000, 2'd1);
        send_byte(8'hAD);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'hEA);
        idle(3);

        // Reset while awaiting the high operand byte
        send_byte(8'h20);
        send_byte(8'h34);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_dout_valid", {31'h0, dout_valid}, 32'd0);
        chk("midrst_din_ready",  {31'h0, din_ready},  32'd1);
        @(posedge clk); #1;
        push(16'h0200, 8'hEA, 16'h0000, 2'd1);
        send_byte(8'hEA);
        idle(4);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Sits directly downstream of the fetch byte FIFO in the front end.
- Consumes the in-order stream of instruction bytes through a valid/ready handshake and assembles complete 6502 instructions: opcode plus 0, 1 or 2 operand bytes.
- Tags each instruction with its fetch PC and presents it to decode through a one-entry valid/ready output register.
- A redirect input flushes any partially assembled instruction and reloads the PC.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset (overwritten by the first redirect).

Ports:
- clk  input  1  clock
- rst  input  1  reset; rst synchronous, active-high; clock clk
- din  input  8  instruction byte from fetch FIFO
- din_valid  input  1  din holds a byte
- din_ready  output  1  byte accepted on this edge when din_valid & din_ready
- redirect_valid  input  1  flush and reload PC
- redirect_pc  input  16  new PC, the address of the next byte on din
- dout_pc  output  16  address of the opcode byte
- dout_opcode  output  8  opcode
- dout_operand  output  16  {hi, lo} operand; unused bytes are 0
- dout_len  output  2  instruction length, 1..3
- dout_valid  output  1  assembled instruction available
- dout_ready  input  1  consumer takes instruction when dout_valid & dout_ready

Behaviour:
- States:
  - OPC: awaiting opcode.
  - LO: awaiting operand low byte.
  - HI: awaiting operand high byte.
  - FULL: instruction held, dout_valid=1.
- Reset values: state OPC, dout_valid 0, dout_opcode/operand/len 0, byte PC (next_pc) = RESET_PC, dout_pc 0.
- din_ready:
  - 0 when redirect_valid=1.
  - Otherwise 1 in OPC/LO/HI.
  - In FULL, din_ready = dout_ready, so a new opcode may load on the same edge the held instruction drains.
  - din_ready must not depend on din_valid.
- Accepting a byte always increments next_pc by 1, modulo 2^16 (FFFF -> 0000).
- Opcode accept:
  - Latch dout_opcode=din, dout_pc=next_pc, dout_operand=0, dout_len=L(din).
  - Next state: FULL if L=1, else LO.
- LO accept: latch operand[7:0]. Next state: FULL if len=2, else HI.
- HI accept: latch operand[15:8]. Next state: FULL.
- FULL:
  - dout_pc, dout_opcode, dout_operand and dout_len hold stable until the handshake.
  - On dout_ready without a byte: state goes to OPC.
  - On dout_ready with a byte: the byte is treated as the new opcode.
- Length rule L(op), with H = op[7:4] and N = op[3:0]:
  - N=0:
    - H=2: 3.
    - H=4 or H=6: 1.
    - All other H, including 00 BRK + signature byte: 2.
  - N=1,3,4,5,6,7: 2.
  - N=2: 2 if H in {8,A,C,E}, else 1.
  - N=8 or N=A: 1.
  - N=9 or N=B: 2 if H is even, else 3.
  - N=C,D,E,F: 3.
- Redirect:
  - redirect_valid has priority over din in every state.
  - Next state OPC, partial bytes discarded, next_pc = redirect_pc, dout_valid = 0.
  - A dout handshake in the same cycle still counts as completed.
  - The upstream FIFO flush is not this block's responsibility.
- Throughput: 1 byte/cycle sustained. A 1-byte instruction appears at dout the cycle after its byte is accepted; back-to-back 1-byte instructions can issue every cycle.
- rst mid-instruction: everything returns to reset values on the next edge and partial bytes are lost.

Test Plan:
- Reset, RESET_PC=16'h0200, stream A9 05 -> one output: pc=0200, opcode=A9, operand=0005, len=2.
- Stream 4C 34 12 EA with dout_ready=1 -> outputs {pc 0200, 4C, 1234, len 3} then {pc 0203, EA, 0000, len 1} on the following cycle; din_ready never drops.
- Hold dout_ready=0 while streaming E8 E8 -> first E8 held in FULL, din_ready=0; raise dout_ready -> both E8 delivered on consecutive cycles, pcs 0200 and 0201.
- Accept 20 and 00 (JSR, low byte only), assert redirect_valid with redirect_pc=8000, then send 60 -> partial JSR never appears; output pc=8000, opcode=60, len=1.
- redirect_pc=FFFE, stream AD 10 20 -> output pc=FFFE, len 3; next opcode tagged pc=0001.
- Assert rst while in HI -> dout_valid=0 and din_ready=1 the next cycle; next byte tagged RESET_PC.
